// File: rtl/spi_xfer_seq_if.sv
// spi_xfer_seq_if: byte streams plus SPI host core register bus seen by the sequencer
interface spi_xfer_seq_if;
  logic        tx_valid_i;
  logic [7:0]  tx_data_i;
  logic        tx_ready_o;
  logic        rx_valid_o;
  logic [7:0]  rx_data_o;
  logic        rx_ready_i;
  logic [7:0]  addr_o;
  logic [31:0] wdata_o;
  logic [3:0]  be_o;
  logic        we_o;
  logic        re_o;
  logic [31:0] rdata_i;
  logic        intr_i;
  logic        busy_o;
  logic        err_o;
  modport master (
    input  tx_valid_i, tx_data_i, rx_ready_i, rdata_i, intr_i,
    output tx_ready_o, rx_valid_o, rx_data_o, addr_o, wdata_o, be_o, we_o, re_o, busy_o, err_o
  );
  modport slave (
    output tx_valid_i, tx_data_i, rx_ready_i, rdata_i, intr_i,
    input  tx_ready_o, rx_valid_o, rx_data_o, addr_o, wdata_o, be_o, we_o, re_o, busy_o, err_o
  );
endinterface

// File: rtl/spi_xfer_seq.sv
// spi_xfer_seq: programs the SPI host core once, then runs one TX0/GO/wait/RX0 sequence per streamed byte
module spi_xfer_seq #(
  parameter logic [7:0] CLK_DIV     = 8'd4,
  parameter logic [7:0] SS_MASK     = 8'h01,
  parameter logic       TX_NEG      = 1'b1,
  parameter logic       RX_NEG      = 1'b0,
  parameter logic       LSB_FIRST   = 1'b0,
  parameter int         TIMEOUT_CYC = 1024
) (
  input logic            clk_i,
  input logic            rst_ni,
  spi_xfer_seq_if.master bus
);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [31:0] CTRL_WORD = {18'b0, 1'b1, 1'b1, LSB_FIRST, TX_NEG, RX_NEG, 1'b1, 1'b0, 7'd8};
  if (TIMEOUT_CYC < 16 * (int'(CLK_DIV) + 1) + 8) begin : g_bad_timeout
    $error("TIMEOUT_CYC too small for one byte at CLK_DIV");
  end
  typedef enum logic [3:0] {INIT_DIV, INIT_SS, IDLE, WR_TX, WR_CTRL, WAIT_DONE, RD_ADDR, RD_CAP, PUSH} state_e;
  state_e          state_q, state_d;
  logic            run_q;
  logic [7:0]      byte_q, byte_d, rx_data_q, rx_data_d;
  logic [WW-1:0]   wdog_q, wdog_d;
  logic            expire, init_on;
  logic            unused_rdata;
  assign unused_rdata = ^bus.rdata_i[31:8];
  assign expire  = wdog_q == WW'(TIMEOUT_CYC - 1);
  // run_q keeps every output quiet while reset is held; INIT_DIV waits for it
  assign init_on = run_q && state_q == INIT_DIV;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= INIT_DIV;
      run_q     <= 1'b0;
      byte_q    <= '0;
      rx_data_q <= '0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      byte_q    <= byte_d;
      rx_data_q <= rx_data_d;
      wdog_q    <= wdog_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    rx_data_d = rx_data_q;
    wdog_d    = wdog_q;
    case (state_q)
      INIT_DIV:  state_d = run_q ? INIT_SS : INIT_DIV;
      INIT_SS:   state_d = IDLE;
      IDLE: if (bus.tx_valid_i) begin
        byte_d  = bus.tx_data_i;
        state_d = WR_TX;
      end
      WR_TX:     state_d = WR_CTRL;
      WR_CTRL: begin
        wdog_d  = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        wdog_d  = wdog_q + 1'b1;
        state_d = bus.intr_i ? RD_ADDR : expire ? IDLE : WAIT_DONE;
      end
      RD_ADDR:   state_d = RD_CAP;
      RD_CAP: begin
        rx_data_d = bus.rdata_i[7:0];
        state_d   = PUSH;
      end
      PUSH:      state_d = bus.rx_ready_i ? IDLE : PUSH;
      default:   state_d = INIT_DIV;
    endcase
  end
  always_comb begin
    bus.we_o       = init_on || state_q inside {INIT_SS, WR_TX, WR_CTRL};
    bus.re_o       = state_q inside {RD_ADDR, RD_CAP};
    bus.addr_o     = init_on ? 8'h14 : state_q == INIT_SS ? 8'h18 : state_q == WR_CTRL ? 8'h10 : 8'h00;
    bus.wdata_o    = init_on ? {24'b0, CLK_DIV} : state_q == INIT_SS ? {24'b0, SS_MASK} :
                     state_q == WR_TX ? {24'b0, byte_q} : state_q == WR_CTRL ? CTRL_WORD : 32'h0;
    bus.be_o       = (init_on || state_q inside {INIT_SS, WR_TX}) ? 4'b0001 : state_q == WR_CTRL ? 4'b0011 : 4'b0000;
    bus.tx_ready_o = state_q == IDLE;
    bus.rx_valid_o = state_q == PUSH;
    bus.rx_data_o  = rx_data_q;
    bus.busy_o     = run_q && state_q != IDLE;
    bus.err_o      = state_q == WAIT_DONE && expire && !bus.intr_i;
  end
endmodule

// File: tb/tb_spi_xfer_seq.sv
// tb_spi_xfer_seq: loopback core model plus byte scoreboard around spi_xfer_seq
module tb_spi_xfer_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   intr_cnt = 0;
  int   we_cnt = 0;
  int   re_cnt = 0;
  bit   suppress = 1'b0;
  logic [7:0] core_tx = 8'h00;
  logic [7:0] core_rx = 8'h00;
  logic [7:0] exp_q[$];
  spi_xfer_seq_if bus ();
  spi_xfer_seq #(.TIMEOUT_CYC(100)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // loopback SPI core: completes 20 cycles after GO, RX0 returns the TX0 byte one cycle after the read address
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    we_cnt   <= we_cnt + int'(bus.we_o);
    re_cnt   <= re_cnt + int'(bus.re_o);
    bus.intr_i  <= 1'b0;
    bus.rdata_i <= (bus.re_o && bus.addr_o == 8'h00) ? {24'b0, core_rx} : 32'h0;
    if (bus.we_o && bus.addr_o == 8'h00) core_tx <= bus.wdata_o[7:0];
    if (bus.we_o && bus.addr_o == 8'h10 && bus.wdata_o[8]) intr_cnt <= 20;
    else if (intr_cnt > 0) begin
      intr_cnt <= intr_cnt - 1;
      if (intr_cnt == 1 && !suppress) begin
        bus.intr_i <= 1'b1;
        core_rx    <= core_tx;
      end
    end
    if (cyc > 50000) begin
      $display("FAIL global_timeout cyc=%0d limit=50000", cyc);
      $fatal(1, "bench timeout");
    end
  end
  task automatic send(input logic [7:0] b, input bit expect_rx, output bit ok);
    ok = 1'b0;
    bus.tx_valid_i = 1'b1;
    bus.tx_data_i  = b;
    for (int i = 0; i < 60; i++) begin
      if (bus.tx_ready_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok && expect_rx) exp_q.push_back(b);
    @(negedge clk);
    bus.tx_valid_i = 1'b0;
  endtask
  task automatic wait_rx(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.rx_valid_o) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({bus.we_o, bus.re_o, bus.busy_o, bus.tx_ready_o, bus.rx_valid_o, bus.err_o} !== 6'b0) begin failures++; $display("FAIL reset_ctrl got=%b want=000000", {bus.we_o, bus.re_o, bus.busy_o, bus.tx_ready_o, bus.rx_valid_o, bus.err_o}); end
    checks++; if ({bus.addr_o, bus.wdata_o, bus.be_o, bus.rx_data_o} !== 52'h0) begin failures++; $display("FAIL reset_bus addr=%h wdata=%h be=%h rx=%h want all 0", bus.addr_o, bus.wdata_o, bus.be_o, bus.rx_data_o); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({bus.we_o, bus.addr_o, bus.wdata_o, bus.be_o} !== {1'b1, 8'h14, 32'h4, 4'h1}) begin failures++; $display("FAIL init_div we=%b addr=%h wdata=%h be=%h want 1/14/00000004/1", bus.we_o, bus.addr_o, bus.wdata_o, bus.be_o); end
    checks++; if (bus.tx_ready_o !== 1'b0) begin failures++; $display("FAIL init_div_ready got=%b want=0", bus.tx_ready_o); end
    @(negedge clk);
    checks++; if ({bus.we_o, bus.addr_o, bus.wdata_o, bus.be_o} !== {1'b1, 8'h18, 32'h1, 4'h1}) begin failures++; $display("FAIL init_ss we=%b addr=%h wdata=%h be=%h want 1/18/00000001/1", bus.we_o, bus.addr_o, bus.wdata_o, bus.be_o); end
    @(negedge clk);
    checks++; if ({bus.tx_ready_o, bus.busy_o, bus.we_o} !== 3'b100) begin failures++; $display("FAIL idle_after_init ready,busy,we=%b want=100", {bus.tx_ready_o, bus.busy_o, bus.we_o}); end
  endtask
  task automatic test_loopback;
    bit ok;
    bit busy_bad = 1'b0;
    logic [7:0] e;
    send(8'hA5, 1'b1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL lb_accept got=0 want=1"); end
    checks++; if ({bus.we_o, bus.addr_o, bus.wdata_o, bus.be_o, bus.busy_o} !== {1'b1, 8'h00, 32'hA5, 4'h1, 1'b1}) begin failures++; $display("FAIL lb_wr_tx we=%b addr=%h wdata=%h be=%h busy=%b want 1/00/000000a5/1/1", bus.we_o, bus.addr_o, bus.wdata_o, bus.be_o, bus.busy_o); end
    @(negedge clk);
    checks++; if ({bus.we_o, bus.addr_o, bus.wdata_o, bus.be_o} !== {1'b1, 8'h10, 32'h00003508, 4'h3}) begin failures++; $display("FAIL lb_ctrl we=%b addr=%h wdata=%h be=%h want 1/10/00003508/3", bus.we_o, bus.addr_o, bus.wdata_o, bus.be_o); end
    for (int i = 0; i < 300 && !bus.rx_valid_o; i++) begin
      if (!bus.busy_o) busy_bad = 1'b1;
      @(negedge clk);
    end
    checks++; if (busy_bad) begin failures++; $display("FAIL lb_busy dropped=1 want=0"); end
    wait_rx(ok);
    checks++; if (!ok) begin failures++; $display("FAIL lb_rx_timeout got=0 want=1"); end
    e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
    checks++; if (bus.rx_data_o !== e) begin failures++; $display("FAIL lb_rx_data got=%h want=%h", bus.rx_data_o, e); end
    @(negedge clk);
    checks++; if ({bus.busy_o, bus.tx_ready_o, bus.rx_valid_o} !== 3'b010) begin failures++; $display("FAIL lb_after_hs busy,ready,valid=%b want=010", {bus.busy_o, bus.tx_ready_o, bus.rx_valid_o}); end
  endtask
  task automatic test_backpressure;
    bit ok;
    int bad = 0;
    logic [7:0] e;
    bus.rx_ready_i = 1'b0;
    send(8'h3C, 1'b1, ok);
    wait_rx(ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_rx_timeout got=0 want=1"); end
    bus.tx_valid_i = 1'b1;
    bus.tx_data_i  = 8'h77;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({bus.rx_valid_o, bus.rx_data_o, bus.tx_ready_o, bus.busy_o} !== {1'b1, 8'h3C, 1'b0, 1'b1}) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold bad_cycles=%0d want=0 (valid=%b data=%h ready=%b)", bad, bus.rx_valid_o, bus.rx_data_o, bus.tx_ready_o); end
    bus.rx_ready_i = 1'b1;
    e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
    checks++; if (bus.rx_data_o !== e) begin failures++; $display("FAIL bp_rx_data got=%h want=%h", bus.rx_data_o, e); end
    @(negedge clk);
    checks++; if ({bus.tx_ready_o, bus.rx_valid_o} !== 2'b10) begin failures++; $display("FAIL bp_ready_after_hs ready,valid=%b want=10", {bus.tx_ready_o, bus.rx_valid_o}); end
    send(8'h77, 1'b1, ok);
    checks++; if ({bus.we_o, bus.addr_o, bus.wdata_o[7:0]} !== {1'b1, 8'h00, 8'h77}) begin failures++; $display("FAIL bp_second_wr we=%b addr=%h data=%h want 1/00/77", bus.we_o, bus.addr_o, bus.wdata_o[7:0]); end
    wait_rx(ok);
    e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
    checks++; if (bus.rx_data_o !== e || !ok) begin failures++; $display("FAIL bp_second_rx got=%h want=%h", bus.rx_data_o, e); end
    @(negedge clk);
  endtask
  task automatic test_timeout;
    bit ok;
    bit rx_seen = 1'b0;
    int wc = 0;
    int ec = -1;
    suppress = 1'b1;
    send(8'h55, 1'b0, ok);
    @(negedge clk);
    wc = cyc;
    checks++; if ({bus.we_o, bus.addr_o} !== {1'b1, 8'h10}) begin failures++; $display("FAIL to_ctrl we=%b addr=%h want 1/10", bus.we_o, bus.addr_o); end
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (bus.rx_valid_o) rx_seen = 1'b1;
      if (bus.err_o) begin
        ec = cyc;
        break;
      end
    end
    checks++; if (ec - wc != 100) begin failures++; $display("FAIL to_err_delay got=%0d want=100", ec - wc); end
    @(negedge clk);
    checks++; if ({bus.err_o, bus.tx_ready_o, bus.rx_valid_o, rx_seen} !== 4'b0100) begin failures++; $display("FAIL to_after err,ready,valid,rx_seen=%b want=0100", {bus.err_o, bus.tx_ready_o, bus.rx_valid_o, rx_seen}); end
    suppress = 1'b0;
  endtask
  task automatic test_reset_mid;
    bit ok;
    int bad = 0;
    send(8'h99, 1'b0, ok);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.we_o, bus.re_o, bus.busy_o, bus.tx_ready_o, bus.rx_valid_o, bus.err_o, bus.addr_o, bus.wdata_o} !== 46'h0) begin failures++; $display("FAIL mid_reset_outputs we,re,busy,ready,valid,err=%b addr=%h want all 0", {bus.we_o, bus.re_o, bus.busy_o, bus.tx_ready_o, bus.rx_valid_o, bus.err_o}, bus.addr_o); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({bus.we_o, bus.addr_o, bus.wdata_o} !== {1'b1, 8'h14, 32'h4}) begin failures++; $display("FAIL mid_reinit_div we=%b addr=%h wdata=%h want 1/14/00000004", bus.we_o, bus.addr_o, bus.wdata_o); end
    @(negedge clk);
    checks++; if ({bus.we_o, bus.addr_o, bus.wdata_o} !== {1'b1, 8'h18, 32'h1}) begin failures++; $display("FAIL mid_reinit_ss we=%b addr=%h wdata=%h want 1/18/00000001", bus.we_o, bus.addr_o, bus.wdata_o); end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ({bus.rx_valid_o, bus.re_o, bus.busy_o, bus.tx_ready_o} !== 4'b0001) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL mid_stale_intr bad_cycles=%0d want=0", bad); end
  endtask
  task automatic test_back_to_back;
    bit ok;
    int we0, re0;
    logic [7:0] e;
    bus.rx_ready_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      we0 = we_cnt;
      re0 = re_cnt;
      send(8'(k), 1'b1, ok);
      wait_rx(ok);
      e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
      checks++; if (bus.rx_data_o !== e || !ok) begin failures++; $display("FAIL b2b_rx%0d got=%h want=%h", k, bus.rx_data_o, e); end
      checks++; if (we_cnt - we0 != 2 || re_cnt - re0 != 2) begin failures++; $display("FAIL b2b_strobes%0d we=%0d re=%0d want 2/2", k, we_cnt - we0, re_cnt - re0); end
      @(negedge clk);
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
  endtask
  initial begin
    bus.tx_valid_i = 1'b0;
    bus.tx_data_i  = 8'h00;
    bus.rx_ready_i = 1'b1;
    test_reset;
    test_loopback;
    test_backpressure;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
